// File: rtl/mem_ctrl_8x8.sv
// Request sequencer for the 8x8 BitCell array: one-hot row select, column data and a phased
// write strobe. Define WRITE_VERIFY_EN to read each written row back and flag mismatches.
module mem_ctrl_8x8 #(
    parameter int unsigned ADDR_W        = 3,
    parameter int unsigned DATA_W        = 8,
    parameter int unsigned WR_PULSE_CYC  = 1,  // 1..15
    parameter int unsigned RD_SETTLE_CYC = 1   // 1..15
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_req_valid,
    output logic                     o_req_ready,
    input  logic                     i_req_wr,
    input  logic [ADDR_W-1:0]        i_req_addr,
    input  logic [DATA_W-1:0]        i_req_wdata,
    output logic [(1<<ADDR_W)-1:0]   o_row_sel,
    output logic [DATA_W-1:0]        o_col_inp,
    output logic                     o_wr,
    input  logic [DATA_W-1:0]        i_col_outp,
    output logic                     o_rsp_valid,
    input  logic                     i_rsp_ready,
    output logic [DATA_W-1:0]        o_rsp_rdata,
    output logic                     o_rsp_err
);

    localparam int unsigned     ROWS    = 1 << ADDR_W;
    localparam logic [ROWS-1:0] ROW_ONE = {{(ROWS-1){1'b0}}, 1'b1};
    localparam logic [3:0]      WR_LOAD = 4'(WR_PULSE_CYC - 1);
    localparam logic [3:0]      RD_LOAD = 4'(RD_SETTLE_CYC - 1);

    typedef enum logic [2:0] {
        StIdle,
        StWSetup,
        StWPulse,
        StWHold,
`ifdef WRITE_VERIFY_EN
        StWVerify,
`endif
        StRSetup,
        StRSample,
        StRsp
    } state_e;

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [ROWS-1:0]     row_sel_q, row_sel_d;
    logic [DATA_W-1:0]   col_inp_q, col_inp_d;
    logic                wr_q, wr_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                accept;
    logic                row_active_d;
    logic                wdata_phase_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        accept  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (i_req_valid) begin
                    accept  = 1'b1;
                    state_d = i_req_wr ? StWSetup : StRSetup;
                end
            end
            StWSetup: begin
                state_d = StWPulse;
                cnt_d   = WR_LOAD;
            end
            StWPulse: begin
                if (cnt_q == 4'd0) state_d = StWHold;
                else               cnt_d   = cnt_q - 4'd1;
            end
`ifdef WRITE_VERIFY_EN
            StWHold: begin
                state_d = StWVerify;
                cnt_d   = RD_LOAD;
            end
            StWVerify: begin
                if (cnt_q == 4'd0) begin
                    state_d = StRsp;
                    rdata_d = i_col_outp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
`else
            StWHold: begin
                state_d = StRsp;
                rdata_d = '0;
            end
`endif
            StRSetup: begin
                state_d = StRSample;
                cnt_d   = RD_LOAD;
            end
            StRSample: begin
                if (cnt_q == 4'd0) begin
                    state_d = StRsp;
                    rdata_d = i_col_outp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StRsp: begin
                if (i_rsp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Array-facing pins are registered from the next state so the strobe never glitches.
    always_comb begin
        addr_d        = accept ? i_req_addr : addr_q;
        wdata_d       = accept ? i_req_wdata : wdata_q;
        wdata_phase_d = (state_d == StWSetup) || (state_d == StWPulse) || (state_d == StWHold);
`ifdef WRITE_VERIFY_EN
        wdata_phase_d = wdata_phase_d || (state_d == StWVerify);
`endif
        row_active_d  = wdata_phase_d || (state_d == StRSetup) || (state_d == StRSample);
        row_sel_d     = row_active_d ? (ROW_ONE << addr_d) : '0;
        col_inp_d     = wdata_phase_d ? wdata_d : '0;
        wr_d          = (state_d == StWPulse);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            row_sel_q <= '0;
            col_inp_q <= '0;
            wr_q      <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            row_sel_q <= row_sel_d;
            col_inp_q <= col_inp_d;
            wr_q      <= wr_d;
            rdata_q   <= rdata_d;
        end
    end

`ifdef WRITE_VERIFY_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (state_q == StRSample && cnt_q == 4'd0) begin
            err_d = 1'b0;
        end else if (state_q == StWVerify && cnt_q == 4'd0) begin
            err_d = (i_col_outp != wdata_q);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) err_q <= 1'b0;
        else       err_q <= err_d;
    end

    assign o_rsp_err = err_q;
`else
    assign o_rsp_err = 1'b0;
`endif

    assign o_req_ready = (state_q == StIdle);
    assign o_rsp_valid = (state_q == StRsp);
    assign o_row_sel   = row_sel_q;
    assign o_col_inp   = col_inp_q;
    assign o_wr        = wr_q;
    assign o_rsp_rdata = rdata_q;

endmodule

// File: tb/tb_mem_ctrl_8x8.sv
// Bench for mem_ctrl_8x8: a default instance and a WR_PULSE_CYC=3/RD_SETTLE_CYC=2 instance,
// each with its own behavioural 8x8 array model; vector table plus hand-written sequences.
module tb_mem_ctrl_8x8;

`ifdef WRITE_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif
    localparam int LAT_WR_A = VERIFY ? 5 : 4;
    localparam int LAT_RD_A = 3;
    localparam int LAT_WR_B = VERIFY ? 8 : 6;
    localparam int LAT_RD_B = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       sel_b = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_wr = 1'b0;
    logic [2:0] req_addr = '0;
    logic [7:0] req_wdata = '0;
    logic       rsp_ready = 1'b0;
    logic [7:0] stuck = 8'h00;

    logic       a_req_ready, a_wr, a_rsp_valid, a_rsp_err;
    logic [7:0] a_row_sel, a_col_inp, a_col_outp, a_rsp_rdata;
    logic       b_req_ready, b_wr, b_rsp_valid, b_rsp_err;
    logic [7:0] b_row_sel, b_col_inp, b_col_outp, b_rsp_rdata;

    mem_ctrl_8x8 u_dut_a (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_valid (req_valid & ~sel_b),
        .o_req_ready (a_req_ready),
        .i_req_wr    (req_wr),
        .i_req_addr  (req_addr),
        .i_req_wdata (req_wdata),
        .o_row_sel   (a_row_sel),
        .o_col_inp   (a_col_inp),
        .o_wr        (a_wr),
        .i_col_outp  (a_col_outp),
        .o_rsp_valid (a_rsp_valid),
        .i_rsp_ready (rsp_ready & ~sel_b),
        .o_rsp_rdata (a_rsp_rdata),
        .o_rsp_err   (a_rsp_err)
    );

    mem_ctrl_8x8 #(
        .WR_PULSE_CYC  (3),
        .RD_SETTLE_CYC (2)
    ) u_dut_b (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_valid (req_valid & sel_b),
        .o_req_ready (b_req_ready),
        .i_req_wr    (req_wr),
        .i_req_addr  (req_addr),
        .i_req_wdata (req_wdata),
        .o_row_sel   (b_row_sel),
        .o_col_inp   (b_col_inp),
        .o_wr        (b_wr),
        .i_col_outp  (b_col_outp),
        .o_rsp_valid (b_rsp_valid),
        .i_rsp_ready (rsp_ready & sel_b),
        .o_rsp_rdata (b_rsp_rdata),
        .o_rsp_err   (b_rsp_err)
    );

    // Behavioural BitCell arrays; stuck forces bits low on readback of array A.
    logic [7:0] mem_a [8];
    logic [7:0] mem_b [8];

    function automatic int oh_idx(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return 0;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                mem_a[i] <= 8'h00;
                mem_b[i] <= 8'h00;
            end
        end else begin
            if (a_wr) mem_a[oh_idx(a_row_sel)] <= a_col_inp;
            if (b_wr) mem_b[oh_idx(b_row_sel)] <= b_col_inp;
        end
    end

    assign a_col_outp = (a_row_sel != 8'h00) ? (mem_a[oh_idx(a_row_sel)] & ~stuck) : 8'h00;
    assign b_col_outp = (b_row_sel != 8'h00) ? mem_b[oh_idx(b_row_sel)] : 8'h00;

    logic       o_ready, o_wr, o_rsp_valid, o_rsp_err;
    logic [7:0] o_row_sel, o_col_inp, o_rsp_rdata;
    assign o_ready     = sel_b ? b_req_ready : a_req_ready;
    assign o_wr        = sel_b ? b_wr        : a_wr;
    assign o_rsp_valid = sel_b ? b_rsp_valid : a_rsp_valid;
    assign o_rsp_err   = sel_b ? b_rsp_err   : a_rsp_err;
    assign o_row_sel   = sel_b ? b_row_sel   : a_row_sel;
    assign o_col_inp   = sel_b ? b_col_inp   : a_col_inp;
    assign o_rsp_rdata = sel_b ? b_rsp_rdata : a_rsp_rdata;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       use_b;
        logic       wr;
        logic [2:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
        logic       exp_err;
        int         exp_lat;
        int         exp_wr_cyc;
    } vec_t;

    function automatic vec_t wv(input logic b, input logic [2:0] a, input logic [7:0] d);
        vec_t v;
        v.use_b      = b;
        v.wr         = 1'b1;
        v.addr       = a;
        v.wdata      = d;
        v.exp_rdata  = VERIFY ? d : 8'h00;
        v.exp_err    = 1'b0;
        v.exp_lat    = b ? LAT_WR_B : LAT_WR_A;
        v.exp_wr_cyc = b ? 3 : 1;
        return v;
    endfunction

    function automatic vec_t rv(input logic b, input logic [2:0] a, input logic [7:0] e);
        vec_t v;
        v.use_b      = b;
        v.wr         = 1'b0;
        v.addr       = a;
        v.wdata      = 8'h00;
        v.exp_rdata  = e;
        v.exp_err    = 1'b0;
        v.exp_lat    = b ? LAT_RD_B : LAT_RD_A;
        v.exp_wr_cyc = 0;
        return v;
    endfunction

    // One request/response; lat counts cycles from the accept edge to the first rsp_valid cycle.
    task automatic run_txn(input vec_t v, output logic [7:0] rdata, output logic err,
                           output int lat, output int wr_cyc, output int first_wr,
                           output logic sel_ok, output logic col_ok);
        @(negedge clk);
        sel_b     = v.use_b;
        req_wr    = v.wr;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_valid = 1'b1;
        #1;
        check("ready_before_accept", o_ready, 1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0; wr_cyc = 0; first_wr = 0; sel_ok = 1'b1; col_ok = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (o_rsp_valid === 1'b1) begin
                lat = n;
                break;
            end
            if (o_row_sel !== (8'h01 << v.addr)) sel_ok = 1'b0;
            if (o_col_inp !== (v.wr ? v.wdata : 8'h00)) col_ok = 1'b0;
            if (o_wr === 1'b1) begin
                wr_cyc++;
                if (first_wr == 0) first_wr = n;
            end
        end
        rdata = o_rsp_rdata;
        err   = o_rsp_err;
        check("rsp_bus_quiet", {o_row_sel, o_wr}, 0);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    vec_t       vecs[$];
    logic [7:0] rdata;
    logic       err, sel_ok, col_ok, flag;
    int         lat, wr_cyc, first_wr;

    initial begin
        vecs.push_back(wv(0, 3'd5, 8'hA5));
        vecs.push_back(rv(0, 3'd5, 8'hA5));
        vecs.push_back(wv(0, 3'd5, 8'h3C));
        vecs.push_back(rv(0, 3'd5, 8'h3C));
        vecs.push_back(wv(0, 3'd7, 8'h81));
        vecs.push_back(wv(0, 3'd0, 8'h7E));
        vecs.push_back(rv(0, 3'd7, 8'h81));
        vecs.push_back(rv(0, 3'd0, 8'h7E));
        vecs.push_back(rv(0, 3'd2, 8'h00));
        for (int i = 0; i < 8; i++) vecs.push_back(wv(1, 3'(i), 8'h90 + 8'(i)));
        for (int i = 0; i < 8; i++) vecs.push_back(rv(1, 3'(i), 8'h90 + 8'(i)));

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", o_ready, 1);
        check("rst_row_sel", o_row_sel, 0);
        check("rst_wr", o_wr, 0);
        check("rst_col_inp", o_col_inp, 0);
        check("rst_rsp", {o_rsp_valid, o_rsp_err, o_rsp_rdata}, 0);
        check("rst_b_ready", b_req_ready, 1);
        rst = 1'b0;

        foreach (vecs[i]) begin
            run_txn(vecs[i], rdata, err, lat, wr_cyc, first_wr, sel_ok, col_ok);
            check($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
            check($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
            check($sformatf("v%0d_err", i), err, vecs[i].exp_err);
            check($sformatf("v%0d_wr_cycles", i), wr_cyc, vecs[i].exp_wr_cyc);
            check($sformatf("v%0d_first_wr", i), first_wr, vecs[i].wr ? 2 : 0);
            check($sformatf("v%0d_row_sel", i), sel_ok, 1);
            check($sformatf("v%0d_col_inp", i), col_ok, 1);
        end

        // Backpressure: valid held high throughout, response stalled 5 cycles
        @(negedge clk);
        sel_b = 1'b0; req_wr = 1'b0; req_addr = 3'd7; req_valid = 1'b1; rsp_ready = 1'b0;
        @(posedge clk);
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (a_rsp_valid === 1'b1) begin
                lat = n;
                break;
            end
        end
        check("bp_lat", lat, LAT_RD_A);
        flag = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (!(a_rsp_valid === 1'b1 && a_rsp_rdata === 8'h81 && a_req_ready === 1'b0))
                flag = 1'b0;
            @(negedge clk);
        end
        check("bp_stable", flag, 1);
        check("bp_rdata", a_rsp_rdata, 8'h81);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        check("bp_ready_after_hs", a_req_ready, 1);
        check("bp_no_rsp_after_hs", a_rsp_valid, 0);
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (a_rsp_valid === 1'b1) begin
                lat = n;
                break;
            end
        end
        check("bp_second_lat", lat, LAT_RD_A);
        check("bp_second_rdata", a_rsp_rdata, 8'h81);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;

`ifdef WRITE_VERIFY_EN
        stuck = 8'h01;
        run_txn(wv(0, 3'd6, 8'hFF), rdata, err, lat, wr_cyc, first_wr, sel_ok, col_ok);
        check("vfy_ff_rdata", rdata, 8'hFE);
        check("vfy_ff_err", err, 1);
        run_txn(wv(0, 3'd6, 8'hFE), rdata, err, lat, wr_cyc, first_wr, sel_ok, col_ok);
        check("vfy_fe_rdata", rdata, 8'hFE);
        check("vfy_fe_err", err, 0);
        stuck = 8'h00;
`endif

        // Reset during W_PULSE drops the request
        @(negedge clk);
        sel_b = 1'b0; req_wr = 1'b1; req_addr = 3'd3; req_wdata = 8'h5A; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_pulse_active", a_wr, 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_wr", a_wr, 0);
        check("mid_rst_row_sel", a_row_sel, 0);
        check("mid_rst_rsp_valid", a_rsp_valid, 0);
        check("mid_rst_ready", a_req_ready, 1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        rsp_ready = 1'b1;
        flag = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (a_rsp_valid !== 1'b0 || a_wr !== 1'b0) flag = 1'b1;
        end
        rsp_ready = 1'b0;
        check("mid_rst_no_rsp", flag, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_ctrl_8x8.md
Name: mem_ctrl_8x8

Overview:
- Request sequencer directly upstream of the 8x8 BitCell array.
- Accepts read/write requests over a valid/ready handshake.
- Decodes the address into a one-hot row select and drives column write data and the write strobe into the BitCell i_sel/i_inp/i_wr pins with setup/pulse/hold phasing.
- Samples the array's o_outp column bus back and returns one response beat per request.

Parameters:
- ADDR_W, 3, row address width; number of rows = 2**ADDR_W.
- DATA_W, 8, word width; one column per bit.
- WR_PULSE_CYC, 1, cycles o_wr is held high per write; legal range 1..15.
- RD_SETTLE_CYC, 1, cycles the row is selected before i_col_outp is captured; legal range 1..15.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  synchronous reset, active-high.
- i_req_valid  in  1  request present.
- o_req_ready  out  1  controller can accept a request.
- i_req_wr  in  1  1 = write, 0 = read.
- i_req_addr  in  ADDR_W  row address.
- i_req_wdata  in  DATA_W  write data.
- o_row_sel  out  2**ADDR_W  one-hot row select, goes to BitCell i_sel.
- o_col_inp  out  DATA_W  column write data, goes to BitCell i_inp.
- o_wr  out  1  write strobe, goes to BitCell i_wr.
- i_col_outp  in  DATA_W  column read bus from BitCell o_outp.
- o_rsp_valid  out  1  response present.
- i_rsp_ready  in  1  consumer accepts the response.
- o_rsp_rdata  out  DATA_W  read data (write: see Optional Feature).
- o_rsp_err  out  1  write-verify mismatch.

Behaviour:
- Reset:
  - i_rst sampled high puts the FSM in IDLE.
  - o_row_sel, o_col_inp, o_wr, o_rsp_valid, o_rsp_rdata and o_rsp_err all go to 0; o_req_ready goes to 1 on the next edge.
  - Reset mid-operation drops the in-flight request with no response; o_wr and o_row_sel are 0 from the cycle after reset is sampled.
- Handshake:
  - o_req_ready = (state == IDLE).
  - Acceptance happens on a cycle where i_req_valid && o_req_ready; addr, wr and wdata are latched that cycle.
  - One request in flight; no pipelining.
- FSM states: IDLE, W_SETUP, W_PULSE, W_HOLD, W_VERIFY (feature only), R_SETUP, R_SAMPLE, RSP.
- Write path:
  - IDLE → W_SETUP (1 cycle): row_sel one-hot, col_inp = wdata, wr = 0.
  - W_PULSE (WR_PULSE_CYC cycles): wr = 1.
  - W_HOLD (1 cycle): wr = 0, row_sel and col_inp held.
  - Then RSP.
- Read path:
  - IDLE → R_SETUP (1 cycle): row_sel one-hot, wr = 0, col_inp = 0.
  - R_SAMPLE (RD_SETTLE_CYC cycles): i_col_outp captured into o_rsp_rdata on the last R_SAMPLE edge.
  - Then RSP.
- RSP:
  - row_sel = 0, wr = 0, o_rsp_valid = 1.
  - Data and error are held stable until i_rsp_ready is high, then IDLE on the next edge.
- Latency (accept at cycle T, default parameters):
  - Write: rsp_valid at T+4 (T+3+WR_PULSE_CYC).
  - Read: rsp_valid at T+3 (T+2+RD_SETTLE_CYC).
- Invariants:
  - o_row_sel has at most one bit set.
  - o_wr = 1 only while exactly one row bit is set.
  - o_wr is never high in IDLE, R_*, or RSP.
  - o_col_inp changes only in IDLE→W_SETUP or on leaving W_HOLD (or W_VERIFY).
- Simultaneous events:
  - i_req_valid during RSP is not accepted (o_req_ready = 0).
  - A new request is accepted no earlier than the cycle after the RSP handshake.
- Address wrap: all 2**ADDR_W addresses are valid; address 7 selects o_row_sel[7].
- Phase counter width is 4 bits; it reloads on every phase entry.

Optional Feature:
- Macro: WRITE_VERIFY_EN.
- Defined:
  - After W_HOLD the FSM enters W_VERIFY for RD_SETTLE_CYC cycles (row_sel held, wr = 0).
  - i_col_outp is captured on the last edge; o_rsp_rdata = readback.
  - o_rsp_err = (readback != latched wdata).
  - Write latency becomes T+4+WR_PULSE_CYC+... i.e. T+5 at default parameters.
- Undefined:
  - No W_VERIFY state.
  - Write response has o_rsp_rdata = 0 and o_rsp_err is tied 0.

Test Plan:
- Reset: hold i_rst 2 cycles during an active W_PULSE → next cycle o_wr = 0, o_row_sel = 0, o_rsp_valid = 0, o_req_ready = 1; no response ever appears.
- Write, default parameters: addr = 5, wdata = 0xA5, accept at T → o_row_sel = 0x20 at T+1..T+3; o_col_inp = 0xA5; o_wr = 1 only at T+2; o_rsp_valid at T+4.
- Read: model array returns 0x3C on row 5, read addr = 5 → o_rsp_rdata = 0x3C with o_rsp_valid at T+3; o_wr stays 0 throughout.
- Backpressure: hold i_rsp_ready = 0 for 5 cycles with i_req_valid = 1 continuously → rsp data stable, o_req_ready = 0; the second request is accepted the cycle after the handshake.
- Parameter sweep: WR_PULSE_CYC = 3, RD_SETTLE_CYC = 2 → o_wr high exactly 3 cycles; read rsp at T+4; all 8 addresses give the correct one-hot select.
- WRITE_VERIFY_EN: model forces bit 0 stuck at 0, write 0xFF → o_rsp_rdata = 0xFE, o_rsp_err = 1; write 0xFE → o_rsp_err = 0.
